// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit-side FIFO controller.
//   state_t    - launch FSM state encoding (IDLE, WAIT)
//   DATA_W_DEF - default byte width
package uart_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1
   } state_t;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered occupancy and a sticky overflow flag.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_dv, wr_data     - write strobe and data
//   rd_en              - pop request (ignored when empty)
//   ovf_clr            - clears the overflow flag (a simultaneous drop wins)
//   rd_data            - entry at the read pointer (valid whenever not empty)
//   full, empty, count - occupancy status, all derived from the count register
//   overflow           - sticky: a write arrived while full with no pop
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_dv,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   input  logic                       ovf_clr,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_nxt_s;
   logic              overflow_r;
   logic              pop_s;
   logic              wr_acc_s;
   logic              drop_s;

   // Flags come straight from the count register, so they change only at a clock edge.
   assign full     = (count_r == CW'(DEPTH));
   assign empty    = (count_r == {CW{1'b0}});
   assign count    = count_r;
   assign overflow = overflow_r;
   assign rd_data  = mem_r[rd_ptr_r];

   // A pop frees a slot in the same cycle, so a write while full is still accepted then.
   assign pop_s    = rd_en & ~empty;
   assign wr_acc_s = wr_dv & (~full | pop_s);
   assign drop_s   = wr_dv & full & ~pop_s;

   // Next occupancy from the accept/pop pair.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_acc_s, pop_s})
         2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap modulo DEPTH by width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         count_r <= count_nxt_s;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (ovf_clr) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: queues received bytes and launches them one at a time into uart_tx.
// Ports:
//   i_Clock, i_Rst_n        - clock, asynchronous active-low reset
//   i_Wr_DV, i_Wr_Byte      - write strobe/data from uart_rx
//   o_Full, o_Empty, o_Count- FIFO occupancy status
//   o_Overflow, i_Ovf_Clr   - sticky dropped-write flag and its clear
//   o_Tx_DV, o_Tx_Byte      - one-cycle launch pulse and held byte to uart_tx
//   i_Tx_Active, i_Tx_Done  - status from uart_tx
// After reset the FSM sits in IDLE and waits for i_Tx_Active to drop, so a byte
// already inside uart_tx completes without being overrun.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                   i_Clock,
   input  logic                   i_Rst_n,
   input  logic                   i_Wr_DV,
   input  logic [DATA_W-1:0]      i_Wr_Byte,
   output logic                   o_Full,
   output logic                   o_Empty,
   output logic [$clog2(DEPTH):0] o_Count,
   output logic                   o_Overflow,
   input  logic                   i_Ovf_Clr,
   output logic                   o_Tx_DV,
   output logic [DATA_W-1:0]      o_Tx_Byte,
   input  logic                   i_Tx_Active,
   input  logic                   i_Tx_Done
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic              pop_s;
   logic [DATA_W-1:0] fifo_rd_data_s;
   logic              tx_dv_r;
   logic [DATA_W-1:0] tx_byte_r;

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk      (i_Clock),
      .rst_n    (i_Rst_n),
      .wr_dv    (i_Wr_DV),
      .wr_data  (i_Wr_Byte),
      .rd_en    (pop_s),
      .ovf_clr  (i_Ovf_Clr),
      .rd_data  (fifo_rd_data_s),
      .full     (o_Full),
      .empty    (o_Empty),
      .count    (o_Count),
      .overflow (o_Overflow)
   );

   // Launch FSM next-state and pop decision.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (!o_Empty && !i_Tx_Active) begin
               pop_s       = 1'b1;
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (i_Tx_Done) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Launch registers: the pulse lasts one cycle, the byte holds until the next pop.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         tx_dv_r   <= 1'b0;
         tx_byte_r <= {DATA_W{1'b0}};
      end else begin
         tx_dv_r <= pop_s;
         if (pop_s) begin
            tx_byte_r <= fifo_rd_data_s;
         end else begin
            tx_byte_r <= tx_byte_r;
         end
      end
   end

   assign o_Tx_DV   = tx_dv_r;
   assign o_Tx_Byte = tx_byte_r;

endmodule : uart_tx_fifo_ctrl

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed self-checking bench for uart_tx_fifo_ctrl (DEPTH=16, DATA_W=8).
module tb_uart_tx_fifo_ctrl;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 8;
   localparam int CW     = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_dv;
   logic [DATA_W-1:0] wr_byte;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              ovf_clr;
   logic              tx_dv;
   logic [DATA_W-1:0] tx_byte;
   logic              tx_active;
   logic              tx_done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   logic [7:0] rnd_b;
   logic       seen_dv;
   int         sent;
   int         got;
   int         gap;
   int         busy;

   always #5 clk = ~clk;

   uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Wr_DV     (wr_dv),
      .i_Wr_Byte   (wr_byte),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Count     (count),
      .o_Overflow  (overflow),
      .i_Ovf_Clr   (ovf_clr),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_empty"},    32'(empty),    32'd1);
      check({tag, "_full"},     32'(full),     32'd0);
      check({tag, "_count"},    32'(count),    32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_tx_dv"},    32'(tx_dv),    32'd0);
      check({tag, "_tx_byte"},  32'(tx_byte),  32'h0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00; ovf_clr = 1'b0;
      tx_active = 1'b0; tx_done = 1'b0;
      #2;
      check_reset_values("reset");
      step(); step();
      rst_n = 1'b1;
      step();

      // 1: single write, launch two edges later
      wr_dv = 1'b1; wr_byte = 8'hA5;
      step();
      wr_dv = 1'b0;
      check("t1_empty_n1", 32'(empty), 32'd0);
      check("t1_count_n1", 32'(count), 32'd1);
      check("t1_txdv_n1",  32'(tx_dv), 32'd0);
      step();
      check("t1_txdv_n2",   32'(tx_dv),   32'd1);
      check("t1_txbyte_n2", 32'(tx_byte), 32'hA5);
      check("t1_empty_n2",  32'(empty),   32'd1);
      check("t1_count_n2",  32'(count),   32'd0);
      step();
      check("t1_txdv_width", 32'(tx_dv),   32'd0);
      check("t1_txbyte_hold", 32'(tx_byte), 32'hA5);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();

      // 2: fill to DEPTH with the transmitter busy
      tx_active = 1'b1;
      seen_dv = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         wr_dv = 1'b1; wr_byte = 8'(i);
         step();
         if (tx_dv) seen_dv = 1'b1;
      end
      wr_dv = 1'b0;
      check("t2_full",     32'(full),     32'd1);
      check("t2_count",    32'(count),    32'd16);
      check("t2_no_launch", 32'(seen_dv), 32'd0);
      check("t2_ovf_clear", 32'(overflow), 32'd0);

      // 3: write while full in the same cycle as a pop
      tx_active = 1'b0;
      wr_dv = 1'b1; wr_byte = 8'h11;
      step();
      wr_dv = 1'b0; tx_active = 1'b1;
      check("t3_count",    32'(count),    32'd16);
      check("t3_full",     32'(full),     32'd1);
      check("t3_overflow", 32'(overflow), 32'd0);
      check("t3_txdv",     32'(tx_dv),    32'd1);
      check("t3_txbyte",   32'(tx_byte),  32'h01);

      // 17th write while full and no pop (FSM waiting) is dropped
      wr_dv = 1'b1; wr_byte = 8'h12;
      step();
      wr_dv = 1'b0;
      check("t2_drop_ovf",   32'(overflow), 32'd1);
      check("t2_drop_count", 32'(count),    32'd16);

      // 4: clear, then drop + clear together (set wins), then clear alone
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t4_clear", 32'(overflow), 32'd0);
      wr_dv = 1'b1; wr_byte = 8'h13; ovf_clr = 1'b1;
      step();
      wr_dv = 1'b0; ovf_clr = 1'b0;
      check("t4_set_wins", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t4_clear_alone", 32'(overflow), 32'd0);

      // drain: remaining 0x02..0x11 in order, one launch per Tx_Done
      for (int k = 0; k < DEPTH; k++) begin
         tx_active = 1'b0; tx_done = 1'b1;
         step();
         tx_done = 1'b0;
         step();
         check("t2_drain_txdv",   32'(tx_dv),   32'd1);
         check("t2_drain_txbyte", 32'(tx_byte), 32'(k + 2));
         tx_active = 1'b1;
         step();
         check("t2_drain_width", 32'(tx_dv), 32'd0);
      end
      tx_active = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      check("t2_drained_empty", 32'(empty), 32'd1);
      check("t2_drained_count", 32'(count), 32'd0);
      check("t2_drained_txdv",  32'(tx_dv), 32'd0);

      // 5: reset during a launch with 5 entries still queued
      tx_active = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_dv = 1'b1; wr_byte = 8'(8'h21 + i);
         step();
      end
      wr_dv = 1'b0;
      tx_active = 1'b0;
      step();
      tx_active = 1'b1;
      check("t5_pre_txdv",   32'(tx_dv),   32'd1);
      check("t5_pre_txbyte", 32'(tx_byte), 32'h21);
      check("t5_pre_count",  32'(count),   32'd5);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("t5_async");
      step();
      rst_n = 1'b1;
      seen_dv = 1'b0;
      wr_dv = 1'b1; wr_byte = 8'h31;
      step();
      wr_dv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (tx_dv) seen_dv = 1'b1;
      end
      check("t5_hold_launch", 32'(seen_dv), 32'd0);
      check("t5_hold_count",  32'(count),   32'd1);
      tx_active = 1'b0;
      step();
      check("t5_launch_txdv",   32'(tx_dv),   32'd1);
      check("t5_launch_txbyte", 32'(tx_byte), 32'h31);
      tx_active = 1'b1;
      step();
      tx_active = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();

      // 6: 40 writes at random spacing, transmitter model answers after 10 cycles
      sent = 0; got = 0; gap = 0; busy = 0;
      for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
         if (tx_dv) begin
            if (exp_q.size() > 0) begin
               exp_b = exp_q.pop_front();
               check("t6_byte", 32'(tx_byte), 32'(exp_b));
            end else begin
               check("t6_unexpected_launch", 32'(tx_byte), 32'h100);
            end
            got++;
            busy = 10; tx_active = 1'b1; tx_done = 1'b0;
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               tx_done = 1'b1; tx_active = 1'b0;
            end else begin
               tx_done = 1'b0;
            end
         end else begin
            tx_done = 1'b0;
         end
         if (sent < 40 && gap == 0) begin
            rnd_b = 8'($urandom);
            wr_dv = 1'b1; wr_byte = rnd_b;
            exp_q.push_back(rnd_b);
            sent++;
            gap = $urandom_range(8, 22);
         end else begin
            wr_dv = 1'b0;
            if (gap > 0) gap--;
         end
         step();
      end
      wr_dv = 1'b0; tx_done = 1'b0;
      check("t6_received", 32'(got),      32'd40);
      check("t6_overflow", 32'(overflow), 32'd0);
      check("t6_empty",    32'(empty),    32'd1);
      check("t6_count",    32'(count),    32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_tx_fifo_ctrl
